// File: rtl/error_monitor_reader_if.sv
// Bus bundle between the processor-side read logic and error_monitor_reader.
// The master modport is the requester/environment side and the slave modport is the reader.
interface error_monitor_reader_if #(
    parameter int NBITS = 26
);
    // Strobe semantics, no backpressure: RD_REQ is a level that is accepted only while
    // RD_BUSY=0. SER_DATA is meaningful only while SER_VALID=1, and a bit advances on each
    // BIT_STB. RD_DONE is a single-cycle completion pulse.
    logic             BIT_STB;
    logic             RD_REQ;
    logic [NBITS-1:0] EM_N;
    logic             SER_DATA;
    logic             SER_VALID;
    logic             RD_BUSY;
    logic             RD_DONE;
    logic             EMRS1;
    logic             EMRS2;
    logic             OVERRUN;
    logic             EM_ANY;

    modport master (
        output BIT_STB, RD_REQ, EM_N,
        input  SER_DATA, SER_VALID, RD_BUSY, RD_DONE, EMRS1, EMRS2, OVERRUN, EM_ANY
    );

    modport slave (
        input  BIT_STB, RD_REQ, EM_N,
        output SER_DATA, SER_VALID, RD_BUSY, RD_DONE, EMRS1, EMRS2, OVERRUN, EM_ANY
    );
endinterface

// File: rtl/error_monitor_reader.sv
// Error monitor read side: snapshot EM latches, shift them out serially, then pulse EMRS1/EMRS2.
// Define ERRMON_PARITY_EN to append an odd-parity bit after the last error bit.
module error_monitor_reader #(
    parameter int NBITS   = 26,
    parameter int SPLIT   = 13,
    parameter int RST_LEN = 2
) (
    input  logic                   SIM_CLK,
    input  logic                   SIM_RST,
    error_monitor_reader_if.slave  bus,
    output logic [2:0]             dbg_state
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CAPTURE = 3'd1,
        S_SHIFT   = 3'd2,
        S_CLEAR   = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    localparam int CW = $clog2(NBITS + 2);
    localparam int RW = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
`ifdef ERRMON_PARITY_EN
    localparam int NSENT = NBITS + 1;
`else
    localparam int NSENT = NBITS;
`endif
    localparam logic [CW-1:0] LAST     = CW'(NSENT - 1);
    localparam logic [RW-1:0] RCNT_END = RW'(RST_LEN - 1);

    state_e           state_q, state_d;
    logic [NBITS-1:0] snap_q, snap_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic             sup1_q, sup1_d;
    logic             sup2_q, sup2_d;
    logic             overrun_q, overrun_d;
    logic             em_any_q, em_any_d;

    logic [NBITS-1:0] em_set;
    logic [NBITS-1:0] late;
    logic [NBITS:0]   word;
    logic             ser_data, ser_valid, emrs1, emrs2;

    assign em_set = ~bus.EM_N;
    // Errors that are latched now but were absent from the snapshot would be lost by a clear.
    assign late   = em_set & ~snap_q;

`ifdef ERRMON_PARITY_EN
    assign word = {~^snap_q, snap_q};
`else
    assign word = {1'b0, snap_q};
`endif

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        cnt_d     = cnt_q;
        rcnt_d    = rcnt_q;
        sup1_d    = sup1_q;
        sup2_d    = sup2_q;
        overrun_d = overrun_q;
        em_any_d  = |em_set;
        ser_data  = 1'b0;
        ser_valid = 1'b0;
        emrs1     = 1'b0;
        emrs2     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.RD_REQ) begin
                    state_d   = S_CAPTURE;
                    overrun_d = 1'b0;
                    sup1_d    = 1'b0;
                    sup2_d    = 1'b0;
                end
            end
            S_CAPTURE: begin
                snap_d  = em_set;
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                ser_valid = 1'b1;
                ser_data  = word[cnt_q];
                if (|late[SPLIT-1:0])     sup1_d = 1'b1;
                if (|late[NBITS-1:SPLIT]) sup2_d = 1'b1;
                if (bus.BIT_STB) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_d = S_CLEAR;
                        rcnt_d  = '0;
                    end
                end
            end
            S_CLEAR: begin
                emrs1 = (|snap_q[SPLIT-1:0]) & ~sup1_q;
                emrs2 = (|snap_q[NBITS-1:SPLIT]) & ~sup2_q;
                if (sup1_q || sup2_q) overrun_d = 1'b1;
                if (rcnt_q == RCNT_END) state_d = S_DONE;
                else                    rcnt_d  = rcnt_q + 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge SIM_CLK) begin
        if (SIM_RST) begin
            state_q   <= S_IDLE;
            snap_q    <= '0;
            cnt_q     <= '0;
            rcnt_q    <= '0;
            sup1_q    <= 1'b0;
            sup2_q    <= 1'b0;
            overrun_q <= 1'b0;
            em_any_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            cnt_q     <= cnt_d;
            rcnt_q    <= rcnt_d;
            sup1_q    <= sup1_d;
            sup2_q    <= sup2_d;
            overrun_q <= overrun_d;
            em_any_q  <= em_any_d;
        end
    end

    // Outputs decode the registered state, so a reset edge drops them all at once.
    assign bus.SER_DATA  = ser_data;
    assign bus.SER_VALID = ser_valid;
    assign bus.RD_BUSY   = (state_q != S_IDLE);
    assign bus.RD_DONE   = (state_q == S_DONE);
    assign bus.EMRS1     = emrs1;
    assign bus.EMRS2     = emrs2;
    assign bus.OVERRUN   = overrun_q;
    assign bus.EM_ANY    = em_any_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_error_monitor_reader.sv
// Directed bench for error_monitor_reader: serial word, clear pulses, overrun suppression,
// back-to-back reads and reset abort.
module tb_error_monitor_reader;
`ifdef ERRMON_PARITY_EN
    localparam int NSENT = 27;
`else
    localparam int NSENT = 26;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] dbg_state;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    error_monitor_reader_if #(.NBITS(26)) bus();

    error_monitor_reader #(.NBITS(26), .SPLIT(13), .RST_LEN(2)) dut (
        .SIM_CLK   (clk),
        .SIM_RST   (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_state"}, dbg_state, 0);
        check({tag, "_valid"}, bus.SER_VALID, 0);
        check({tag, "_data"},  bus.SER_DATA, 0);
        check({tag, "_busy"},  bus.RD_BUSY, 0);
        check({tag, "_done"},  bus.RD_DONE, 0);
        check({tag, "_emrs1"}, bus.EMRS1, 0);
        check({tag, "_emrs2"}, bus.EMRS2, 0);
        check({tag, "_ovr"},   bus.OVERRUN, 0);
        check({tag, "_emany"}, bus.EM_ANY, 0);
    endtask

    // Accept a read and step into SHIFT; a BIT_STB is presented during CAPTURE and must be ignored.
    task automatic start_read(input logic [25:0] em0, input bit hold);
        bus.EM_N   = em0;
        bus.RD_REQ = 1'b1;
        tick();
        check("cap_state", dbg_state, 1);
        check("cap_busy", bus.RD_BUSY, 1);
        check("cap_ovr_clr", bus.OVERRUN, 0);
        check("cap_emany", bus.EM_ANY, {31'd0, |(~em0)});
        bus.RD_REQ  = hold;
        bus.BIT_STB = 1'b1;
        tick();
        bus.BIT_STB = 1'b0;
        check("shift_state", dbg_state, 2);
    endtask

    task automatic do_read(input logic [25:0] em0, input int mid_at, input logic [25:0] em1,
                           input logic [25:0] exp_snap, input logic exp_rs1, input logic exp_rs2,
                           input logic exp_ovr, input bit hold);
        logic [26:0] w;
        w = {~^exp_snap, exp_snap};
        start_read(em0, hold);
        for (int k = 0; k < NSENT; k++) begin
            if (k == mid_at) bus.EM_N = em1;
            check("ser_valid", bus.SER_VALID, 1);
            check("ser_bit", bus.SER_DATA, {31'd0, w[k]});
            if (!hold && k == 4) bus.RD_REQ = 1'b1;
            tick();
            bus.RD_REQ = hold;
            check("ser_bit_hold", bus.SER_DATA, {31'd0, w[k]});
            bus.BIT_STB = 1'b1;
            tick();
            bus.BIT_STB = 1'b0;
        end
        for (int r = 0; r < 2; r++) begin
            check("clr_state", dbg_state, 3);
            check("clr_valid", bus.SER_VALID, 0);
            check("clr_data", bus.SER_DATA, 0);
            check("emrs1", bus.EMRS1, {31'd0, exp_rs1});
            check("emrs2", bus.EMRS2, {31'd0, exp_rs2});
            tick();
        end
        check("done_pulse", bus.RD_DONE, 1);
        check("done_emrs1", bus.EMRS1, 0);
        check("done_emrs2", bus.EMRS2, 0);
        check("done_ovr", bus.OVERRUN, {31'd0, exp_ovr});
        tick();
        check("idle_done", bus.RD_DONE, 0);
        check("idle_busy", bus.RD_BUSY, 0);
        check("idle_state", dbg_state, 0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.BIT_STB = 1'b0;
        bus.RD_REQ  = 1'b0;
        bus.EM_N    = '1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_all_zero("post_reset");

        // No errors latched: all-zero word, no clear pulses.
        do_read(26'h3FFFFFF, -1, 26'h0, 26'h0, 1'b0, 1'b0, 1'b0, 1'b0);

        // EM1 and EM26: both halves cleared.
        do_read(~26'h2000001, -1, 26'h0, 26'h2000001, 1'b1, 1'b1, 1'b0, 1'b0);

        // EM3 snapshot, EM6 arrives mid-shift: lower clear suppressed.
        do_read(~26'h0000004, 3, ~26'h0000024, 26'h0000004, 1'b0, 1'b0, 1'b1, 1'b0);
        // Next read clears OVERRUN at accept and reports EM3 and EM6.
        do_read(~26'h0000024, -1, 26'h0, 26'h0000024, 1'b1, 1'b0, 1'b0, 1'b0);

        // EM15 snapshot, EM17 arrives mid-shift: upper clear suppressed.
        do_read(~26'h0004000, 7, ~26'h0014000, 26'h0004000, 1'b0, 1'b0, 1'b1, 1'b0);

        // RD_REQ held high: back-to-back reads, one IDLE cycle between them.
        do_read(~26'h1555555, -1, 26'h0, 26'h1555555, 1'b1, 1'b1, 1'b0, 1'b1);
        do_read(~26'h2AAAAAA, -1, 26'h0, 26'h2AAAAAA, 1'b1, 1'b1, 1'b0, 1'b1);
        do_read(~26'h0001000, -1, 26'h0, 26'h0001000, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset coincident with the 10th BIT_STB.
        start_read(~26'h2000001, 1'b0);
        for (int k = 0; k < 9; k++) begin
            bus.BIT_STB = 1'b1;
            tick();
        end
        check("abort1_pre_state", dbg_state, 2);
        rst = 1'b1;
        tick();
        check_all_zero("abort1");
        rst         = 1'b0;
        bus.BIT_STB = 1'b0;
        tick();
        check("abort1_no_done", bus.RD_DONE, 0);
        check("abort1_idle", dbg_state, 0);

        // Reset during a CLEAR cycle.
        start_read(~26'h2000001, 1'b0);
        for (int k = 0; k < NSENT; k++) begin
            bus.BIT_STB = 1'b1;
            tick();
        end
        bus.BIT_STB = 1'b0;
        check("abort2_clr_state", dbg_state, 3);
        check("abort2_emrs1_pre", bus.EMRS1, 1);
        rst = 1'b1;
        tick();
        check_all_zero("abort2");
        rst = 1'b0;
        tick();
        check("abort2_no_done", bus.RD_DONE, 0);
        check("abort2_idle", dbg_state, 0);

        // Normal read after the aborts.
        do_read(~26'h2000001, -1, 26'h0, 26'h2000001, 1'b1, 1'b1, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
